// File: rtl/md_unit_e_if.sv
// Execute-stage multiply/divide port bundle.
// The pipeline drives the master side; md_unit_e is the slave.
interface md_unit_e_if;
  logic [2:0]  md_op;
  logic        start;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (output md_op, start, flush, a, b,
                  input  busy, hi_o, lo_o);
  modport slave  (input  md_op, start, flush, a, b,
                  output busy, hi_o, lo_o);
endinterface

// File: rtl/md_unit_e.sv
// Execute-stage multiply/divide unit holding architectural HI/LO.
// mult/div results are computed at issue and committed after a fixed latency.
module md_unit_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  md_unit_e_if.slave md
);
  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e        state;
  md_op_e        op;
  logic          busy_q;
  logic [CW-1:0] count;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_skip;
  logic          issue;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_q_s, div_r_s, div_q_u, div_r_u;
  logic signed [31:0] sa, sb;
  logic [31:0]        ub;

  assign op    = md_op_e'(md.md_op);
  assign issue = md.start & ~md.flush & ~busy_q;

  assign prod_s = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
  assign prod_u = {32'd0, md.a} * {32'd0, md.b};

  // Divisor forced to 1 when zero so the datapath stays defined; the result is discarded.
  always_comb begin
    sa      = $signed(md.a);
    sb      = (md.b == '0) ? 32'sd1 : $signed(md.b);
    ub      = (md.b == '0) ? 32'd1 : md.b;
    div_q_s = '0;
    div_r_s = '0;
    if (md.a == 32'h8000_0000 && md.b == 32'hFFFF_FFFF) begin
      div_q_s = 32'h8000_0000;
      div_r_s = '0;
    end else begin
      div_q_s = sa / sb;
      div_r_s = sa % sb;
    end
    div_q_u = md.a / ub;
    div_r_u = md.a % ub;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      count     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_skip <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                {pend_hi, pend_lo} <= (op == OP_MULT) ? prod_s : prod_u;
                pend_skip <= 1'b0;
                count     <= CW'(MULT_CYCLES);
                busy_q    <= 1'b1;
                state     <= ST_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                pend_lo   <= (op == OP_DIV) ? div_q_s : div_q_u;
                pend_hi   <= (op == OP_DIV) ? div_r_s : div_r_u;
                pend_skip <= (md.b == '0);
                count     <= CW'(DIV_CYCLES);
                busy_q    <= 1'b1;
                state     <= ST_BUSY;
              end
              OP_MTHI: hi_q <= md.a;
              OP_MTLO: lo_q <= md.a;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (count == CW'(1)) begin
            if (!pend_skip) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            count  <= '0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi_o = hi_q;
  assign md.lo_o = lo_q;
endmodule

// File: tb/tb_md_unit_e.sv
// Self-checking bench for md_unit_e: vector table with a result scoreboard,
// plus hand-written sequences for busy-stall, flush and mid-op reset.
module tb_md_unit_e;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_e_if bus ();

  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    int          busy_cyc;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.md_op = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
  endtask

  // Drive one op, then count busy cycles and compare against the scoreboard.
  task automatic run_op(input string name, input logic [2:0] op, input logic fl,
                        input logic [31:0] a, input logic [31:0] b, input int busy_cyc,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    logic [63:0] e;
    bus.md_op = op;
    bus.start = 1'b1;
    bus.flush = fl;
    bus.a     = a;
    bus.b     = b;
    sb_q.push_back({eh, el});
    cyc();
    idle_inputs();
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    check({name, " busy_cycles"}, 32'(n), 32'(busy_cyc));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, " hi"}, bus.hi_o, e[63:32]);
      check({name, " lo"}, bus.lo_o, e[31:0]);
    end else begin
      check({name, " scoreboard_empty"}, 32'd1, 32'd0);
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset hi", bus.hi_o, 32'd0);
    check("reset lo", bus.lo_o, 32'd0);

    //               op    fl    a             b             cyc  hi            lo
    vecs.push_back('{3'd2, 1'b0, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE});
    vecs.push_back('{3'd1, 1'b0, 32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{3'd3, 1'b0, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{3'd4, 1'b0, 32'hFFFFFFF9, 32'd2,        10, 32'h00000001, 32'h7FFFFFFC});
    vecs.push_back('{3'd5, 1'b0, 32'h00001234, 32'd0,        0,  32'h00001234, 32'h7FFFFFFC});
    vecs.push_back('{3'd3, 1'b0, 32'd5,        32'd0,        10, 32'h00001234, 32'h7FFFFFFC});
    vecs.push_back('{3'd1, 1'b1, 32'd3,        32'd4,        0,  32'h00001234, 32'h7FFFFFFC});
    vecs.push_back('{3'd6, 1'b1, 32'h0000DEAD, 32'd0,        0,  32'h00001234, 32'h7FFFFFFC});
    vecs.push_back('{3'd3, 1'b0, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000});
    vecs.push_back('{3'd6, 1'b0, 32'h0000CAFE, 32'd0,        0,  32'h00000000, 32'h0000CAFE});
    vecs.push_back('{3'd7, 1'b0, 32'd1,        32'd1,        0,  32'h00000000, 32'h0000CAFE});
    vecs.push_back('{3'd0, 1'b0, 32'd1,        32'd1,        0,  32'h00000000, 32'h0000CAFE});
    vecs.push_back('{3'd3, 1'b0, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{3'd2, 1'b0, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000});
    vecs.push_back('{3'd1, 1'b0, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000});
    vecs.push_back('{3'd4, 1'b0, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E});

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].flush, vecs[i].a, vecs[i].b,
             vecs[i].busy_cyc, vecs[i].exp_hi, vecs[i].exp_lo);

    // MTHI is not bypassed: hi_o shows the old value until the write edge.
    bus.md_op = 3'd5;
    bus.start = 1'b1;
    bus.a     = 32'h00000077;
    #1;
    check("mthi no_bypass", bus.hi_o, 32'h00000002);
    cyc();
    idle_inputs();
    check("mthi written", bus.hi_o, 32'h00000077);

    // Start while busy is ignored: MTHI during a MULTU must not write HI.
    bus.md_op = 3'd2;
    bus.start = 1'b1;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    sb_q.push_back({32'd0, 32'd6});
    cyc();
    bus.md_op = 3'd5;
    bus.a     = 32'h00005555;
    cyc();
    idle_inputs();
    check("busy_ignore hi_mid", bus.hi_o, 32'h00000077);
    n = 1;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    check("busy_ignore cycles", 32'(n), 32'd5);
    if (sb_q.size() > 0) begin
      logic [63:0] e;
      e = sb_q.pop_front();
      check("busy_ignore hi", bus.hi_o, e[63:32]);
      check("busy_ignore lo", bus.lo_o, e[31:0]);
    end

    // Flush during an in-flight op does not cancel it.
    bus.md_op = 3'd2;
    bus.start = 1'b1;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    cyc();
    bus.start = 1'b0;
    bus.flush = 1'b1;
    cyc();
    idle_inputs();
    n = 2;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    check("flush_inflight cycles", 32'(n), 32'd6);
    check("flush_inflight lo", bus.lo_o, 32'd15);

    // Reset three cycles into a DIV aborts it and clears HI/LO.
    bus.md_op = 3'd3;
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    cyc();
    idle_inputs();
    cyc();
    cyc();
    check("reset_mid busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("reset_mid busy", 32'(bus.busy), 32'd0);
    check("reset_mid hi", bus.hi_o, 32'd0);
    check("reset_mid lo", bus.lo_o, 32'd0);
    repeat (12) cyc();
    check("reset_mid late_hi", bus.hi_o, 32'd0);
    check("reset_mid late_lo", bus.lo_o, 32'd0);
    check("reset_mid late_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
